// File: rtl/spi_cmd_ctrl_pkg.sv
// spi_cmd_ctrl_pkg: shared field widths, command/error codes and FSM states for the SPI command path.
package spi_cmd_ctrl_pkg;
    localparam int CMD_BITS = 8;
    localparam int ADDR_BITS = 8;
    localparam int PAYLOAD_BITS = 8;
    localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int DEF_MAX_DUTY = 100;
    localparam logic [CMD_BITS-1:0] CMD_NOP = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_LED_GET = 8'h02;
    localparam logic [CMD_BITS-1:0] CMD_LED_CLR_ALL = 8'h03;
    localparam logic [CMD_BITS-1:0] CMD_STAT_CLR = 8'h04;
    localparam logic [CMD_BITS-1:0] CMD_ERR = 8'hFF;
    localparam logic [PAYLOAD_BITS-1:0] ERR_BAD_CMD = 8'h01;
    localparam logic [PAYLOAD_BITS-1:0] ERR_BAD_ADDR = 8'h02;

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_EXEC, ST_RESP} state_t;

    function automatic logic [PAYLOAD_BITS-1:0] sat_duty(input logic [PAYLOAD_BITS-1:0] p, input int mx);
        return (int'(p) > mx) ? PAYLOAD_BITS'(mx) : p;
    endfunction
endpackage

// File: rtl/spi_cmd_ctrl_cs_sync.sv
// spi_cs_sync: 2-flop synchroniser for the SPI chip select with start/end-of-frame pulse detection.
module spi_cs_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    output logic sof,
    output logic eof
);
    logic meta_q, sync_q, prev_q;

    // Reset high to match an idle bus so releasing rst never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {meta_q, sync_q, prev_q} <= 3'b111;
        else {meta_q, sync_q, prev_q} <= {cs, meta_q, sync_q};
    end

    assign sof = prev_q & ~sync_q;
    assign eof = sync_q & ~prev_q;
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes each completed SPI frame, updates the LED duty bank and arms a response
// frame for the slave to shift out during the following transaction.
module spi_cmd_ctrl
    import spi_cmd_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int MAX_DUTY = DEF_MAX_DUTY
) (
    input  logic                             sysclk,
    input  logic                             rst,
    input  logic                             cs,
    input  logic [CMD_BITS-1:0]              rx_cmd,
    input  logic [ADDR_BITS-1:0]             rx_addr,
    input  logic [PAYLOAD_BITS-1:0]          rx_payload,
    output logic                             slv_tx_enb,
    output logic [MASTER_FRAME_WIDTH-1:0]    slv_frame,
    output logic [NUM_LEDS*PAYLOAD_BITS-1:0] led_duty,
    output logic                             busy,
    output logic                             err
);
    state_t state_q, state_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [PAYLOAD_BITS-1:0] pay_q, pay_d;
    logic [MASTER_FRAME_WIDTH-1:0] resp_q, resp_d, frame_q, frame_d;
    logic resp_vld_q, resp_vld_d, tx_enb_q, tx_enb_d, sof_seen_q, sof_seen_d, err_q, err_d;
    logic [PAYLOAD_BITS-1:0] duty_q [NUM_LEDS];
    logic [PAYLOAD_BITS-1:0] duty_d [NUM_LEDS];
    logic sof, eof, addr_ok, is_set, is_get, is_clr, is_stat, is_nop, bad_cmd, bad_addr;
    logic [PAYLOAD_BITS-1:0] cur, sat;

    spi_cs_sync u_cs_sync (
        .clk(sysclk),
        .rst(rst),
        .cs (cs),
        .sof(sof),
        .eof(eof)
    );

    always_comb begin
        addr_ok = 1'b0;
        cur = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            if (addr_q == ADDR_BITS'(i)) begin
                addr_ok = 1'b1;
                cur = duty_q[i];
            end
    end

    assign sat = sat_duty(pay_q, MAX_DUTY);
    assign is_set = cmd_q == CMD_LED_SET;
    assign is_get = cmd_q == CMD_LED_GET;
    assign is_clr = cmd_q == CMD_LED_CLR_ALL;
    assign is_stat = cmd_q == CMD_STAT_CLR;
    assign is_nop = cmd_q == CMD_NOP;
    assign bad_cmd = !(is_set | is_get | is_clr | is_stat | is_nop);
    assign bad_addr = (is_set | is_get) & !addr_ok;

    // Effects land on entry to EXEC; the registered response is armed on entry to RESP.
    always_comb begin
        state_d = state_q;
        cmd_d = cmd_q;
        addr_d = addr_q;
        pay_d = pay_q;
        resp_d = resp_q;
        resp_vld_d = resp_vld_q;
        duty_d = duty_q;
        err_d = err_q | (eof & (state_q != ST_IDLE));
        frame_d = frame_q;
        tx_enb_d = tx_enb_q & !(eof & sof_seen_q);
        sof_seen_d = (sof_seen_q | (sof & tx_enb_q)) & !eof;
        unique case (state_q)
            ST_IDLE: if (eof) begin
                state_d = ST_CAPTURE;
                cmd_d = rx_cmd;
                addr_d = rx_addr;
                pay_d = rx_payload;
            end
            ST_CAPTURE: begin
                state_d = ST_EXEC;
                resp_vld_d = !is_nop;
                resp_d = bad_cmd  ? {CMD_ERR, addr_q, ERR_BAD_CMD}
                       : bad_addr ? {CMD_ERR, addr_q, ERR_BAD_ADDR}
                       : is_set   ? {CMD_LED_SET, addr_q, sat}
                       : is_get   ? {CMD_LED_GET, addr_q, cur}
                       : {cmd_q, {(ADDR_BITS + PAYLOAD_BITS){1'b0}}};
                err_d = bad_cmd | bad_addr | (err_q & !is_stat) | eof;
                for (int i = 0; i < NUM_LEDS; i++)
                    if (is_clr || (is_set && addr_q == ADDR_BITS'(i))) duty_d[i] = is_clr ? '0 : sat;
            end
            ST_EXEC: begin
                state_d = resp_vld_q ? ST_RESP : ST_IDLE;
                if (resp_vld_q) begin
                    frame_d = resp_q;
                    tx_enb_d = 1'b1;
                    sof_seen_d = 1'b0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q <= '0;
            addr_q <= '0;
            pay_q <= '0;
            resp_q <= '0;
            resp_vld_q <= 1'b0;
            duty_q <= '{default: '0};
            err_q <= 1'b0;
            frame_q <= '0;
            tx_enb_q <= 1'b0;
            sof_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q <= cmd_d;
            addr_q <= addr_d;
            pay_q <= pay_d;
            resp_q <= resp_d;
            resp_vld_q <= resp_vld_d;
            duty_q <= duty_d;
            err_q <= err_d;
            frame_q <= frame_d;
            tx_enb_q <= tx_enb_d;
            sof_seen_q <= sof_seen_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        assign led_duty[i*PAYLOAD_BITS +: PAYLOAD_BITS] = duty_q[i];
    end

    assign slv_tx_enb = tx_enb_q;
    assign slv_frame = frame_q;
    assign busy = state_q != ST_IDLE;
    assign err = err_q;
endmodule
